// File: rtl/text_capture_pkg.sv
// Shared constants, FSM state type and character helpers for the terminal text capture block.
package text_capture_pkg;

    localparam int unsigned BUF_DEPTH  = 8192;
    localparam int unsigned BUF_AW     = 13;
    localparam int unsigned FIFO_DEPTH = 16;

    localparam logic [6:0] CHAR_CR     = 7'h0D;
    localparam logic [7:0] CHAR_LF     = 8'h0A;
    localparam logic [6:0] CHAR_RUBOUT = 7'h5F;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WRITE_LF,
        UPLOAD
    } state_t;

    function automatic logic is_printable(input logic [6:0] c);
        return (c >= 7'h20) && (c <= 7'h5E);
    endfunction

endpackage

// File: rtl/tc_fifo.sv
// 16-deep, 7-bit synchronous FIFO with first-word-fall-through output and synchronous flush.
module tc_fifo
    import text_capture_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_flush,
    input  logic       i_push,
    input  logic [6:0] i_data,
    input  logic       i_pop,
    output logic [6:0] o_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [6:0]  r_mem [FIFO_DEPTH];
    logic [PW:0] r_wptr;
    logic [PW:0] r_rptr;
    logic        w_do_push;
    logic        w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[PW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/text_capture.sv
// Captures CPU terminal output into an 8 KiB buffer (CR expanded to CR/LF, rubout erases)
// and serves it to the HPS through an independent one-cycle-latency read port.
module text_capture
    import text_capture_pkg::*;
(
    input  logic        clk25,
    input  logic        rst_n,
    input  logic        dsp_we,
    input  logic [6:0]  dsp_data,
    input  logic        cap_en,
    input  logic        clear,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [12:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic [13:0] buf_count,
    output logic        overflow
);

    state_t      r_state;
    logic [13:0] r_count;
    logic        r_ovf;
    logic [6:0]  r_char;
    logic [7:0]  r_prev;
    logic [7:0]  r_rd_q;
    logic        r_rd_hit;
    logic [7:0]  r_ram [BUF_DEPTH];

    logic        w_push;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [6:0]  w_fifo_data;
    logic        w_buf_full;
    logic        w_store_char;
    logic        w_wr_en;
    logic [7:0]  w_wr_data;

    assign w_push       = dsp_we && cap_en && !clear;
    assign w_pop        = (r_state == IDLE) && !ioctl_upload && !w_fifo_empty && !clear;
    assign w_buf_full   = (r_count == 14'(BUF_DEPTH));
    assign w_store_char = (r_state == WRITE) && ((r_char == CHAR_CR) || is_printable(r_char));
    assign w_wr_en      = !clear && !w_buf_full && (w_store_char || (r_state == WRITE_LF));
    assign w_wr_data    = (r_state == WRITE_LF) ? CHAR_LF : {1'b0, r_char};

    tc_fifo u_fifo (
        .clk     (clk25),
        .rst_n   (rst_n),
        .i_flush (clear),
        .i_push  (w_push),
        .i_data  (dsp_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // The byte before the write pointer is fetched at pop time so rubout can test it in WRITE.
    always_ff @(posedge clk25) begin
        if (w_wr_en) begin
            r_ram[r_count[BUF_AW-1:0]] <= w_wr_data;
        end
        if (w_pop) begin
            r_prev <= r_ram[r_count[BUF_AW-1:0] - BUF_AW'(1)];
        end
        if (ioctl_rd) begin
            r_rd_q <= r_ram[ioctl_addr];
        end
    end

    always_ff @(posedge clk25) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_char   <= '0;
            r_rd_hit <= 1'b0;
        end else begin
            if (ioctl_rd) begin
                r_rd_hit <= ({1'b0, ioctl_addr} < r_count);
            end
            if (w_push && w_fifo_full) begin
                r_ovf <= 1'b1;
            end
            if (clear) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
                if (r_state != UPLOAD) begin
                    r_state <= IDLE;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (ioctl_upload) begin
                            r_state <= UPLOAD;
                        end else if (w_pop) begin
                            r_char  <= w_fifo_data;
                            r_state <= WRITE;
                        end
                    end
                    WRITE: begin
                        r_state <= (r_char == CHAR_CR) ? WRITE_LF : IDLE;
                        if (w_store_char) begin
                            if (w_buf_full) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_count <= r_count + 14'd1;
                            end
                        end else if ((r_char == CHAR_RUBOUT) && (r_count != '0) && (r_prev != CHAR_LF)) begin
                            r_count <= r_count - 14'd1;
                        end
                    end
                    WRITE_LF: begin
                        r_state <= IDLE;
                        if (w_buf_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_count <= r_count + 14'd1;
                        end
                    end
                    UPLOAD: begin
                        if (!ioctl_upload) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign ioctl_din = r_rd_hit ? r_rd_q : 8'h00;
    assign buf_count = r_count;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_text_capture.sv
// Self-checking bench for text_capture: vector table for character classification,
// scoreboard for HPS reads, directed sequences for overflow, upload, clear and reset.
module tb_text_capture;

    logic        clk25 = 1'b0;
    logic        rst_n = 1'b0;
    logic        dsp_we = 1'b0;
    logic [6:0]  dsp_data = '0;
    logic        cap_en = 1'b1;
    logic        clear = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic        ioctl_rd = 1'b0;
    logic [12:0] ioctl_addr = '0;
    logic [7:0]  ioctl_din;
    logic [13:0] buf_count;
    logic        overflow;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [6:0]  ch;
        logic        cap;
        int unsigned exp_cnt;
    } vec_t;

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  exp;
    } rd_t;

    rd_t  sb[$];
    logic rd_d = 1'b0;

    text_capture dut (
        .clk25        (clk25),
        .rst_n        (rst_n),
        .dsp_we       (dsp_we),
        .dsp_data     (dsp_data),
        .cap_en       (cap_en),
        .clear        (clear),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .buf_count    (buf_count),
        .overflow     (overflow)
    );

    always #5 clk25 = ~clk25;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Read data is compared on the falling edge after the edge that captured ioctl_rd.
    always @(posedge clk25) rd_d <= ioctl_rd;
    always @(negedge clk25) begin
        if (rd_d) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                rd_t e;
                e = sb.pop_front();
                check($sformatf("rd[%0d]", e.addr), {24'd0, ioctl_din}, {24'd0, e.exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic put_char(input logic [6:0] c);
        dsp_data = c;
        dsp_we   = 1'b1;
        tick();
        dsp_we   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic rd(input logic [12:0] a, input logic [7:0] e);
        rd_t r;
        r.addr = a;
        r.exp  = e;
        sb.push_back(r);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
    endtask

    task automatic wait_count(input int exp, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (buf_count == 14'(exp)) break;
            tick();
        end
        check(nm, {18'd0, buf_count}, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        tbl[0]  = '{7'h48, 1'b1, 1};
        tbl[1]  = '{7'h49, 1'b1, 2};
        tbl[2]  = '{7'h0D, 1'b1, 4};
        tbl[3]  = '{7'h07, 1'b1, 4};
        tbl[4]  = '{7'h5F, 1'b1, 4};
        tbl[5]  = '{7'h41, 1'b1, 5};
        tbl[6]  = '{7'h5F, 1'b1, 4};
        tbl[7]  = '{7'h58, 1'b0, 4};
        tbl[8]  = '{7'h7F, 1'b1, 4};
        tbl[9]  = '{7'h20, 1'b1, 5};
        tbl[10] = '{7'h5E, 1'b1, 6};
        tbl[11] = '{7'h1F, 1'b1, 6};

        drain(3);
        check("rst_count", {18'd0, buf_count}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        check("rst_din", {24'd0, ioctl_din}, 0);
        rst_n = 1'b1;
        drain(2);

        foreach (tbl[i]) begin
            cap_en = tbl[i].cap;
            put_char(tbl[i].ch);
            drain(8);
            check($sformatf("tbl%0d_count", i), {18'd0, buf_count}, tbl[i].exp_cnt);
        end
        cap_en = 1'b1;
        check("tbl_ovf", {31'd0, overflow}, 0);

        ioctl_upload = 1'b1;
        drain(2);
        rd(0, 8'h48); rd(1, 8'h49); rd(2, 8'h0D); rd(3, 8'h0A);
        rd(4, 8'h20); rd(6, 8'h00); rd(5, 8'h5E);
        drain(4);
        check("din_hold", {24'd0, ioctl_din}, 32'h5E);
        ioctl_upload = 1'b0;
        drain(2);

        do_clear();
        drain(2);
        check("clr_count", {18'd0, buf_count}, 0);
        rd(0, 8'h00);

        put_char(7'h41); put_char(7'h42); put_char(7'h5F); put_char(7'h43);
        drain(12);
        check("rub_count", {18'd0, buf_count}, 2);
        rd(0, 8'h41); rd(1, 8'h43);
        do_clear();
        put_char(7'h5F);
        drain(6);
        check("rub_empty", {18'd0, buf_count}, 0);

        ioctl_upload = 1'b1;
        drain(2);
        for (int i = 0; i < 10; i++) put_char(7'(8'h30 + i));
        drain(10);
        check("upl_hold_count", {18'd0, buf_count}, 0);
        ioctl_upload = 1'b0;
        wait_count(10, 25, "upl_release_count");
        rd(0, 8'h30); rd(9, 8'h39);

        do_clear();
        ioctl_upload = 1'b1;
        drain(2);
        for (int i = 0; i < 17; i++) put_char(7'(8'h40 + i));
        drain(2);
        check("upl17_ovf", {31'd0, overflow}, 1);
        ioctl_upload = 1'b0;
        wait_count(16, 40, "upl17_count");
        drain(10);
        check("upl17_final", {18'd0, buf_count}, 16);
        rd(15, 8'h4F); rd(16, 8'h00);

        clear    = 1'b1;
        dsp_data = 7'h5A;
        dsp_we   = 1'b1;
        tick();
        clear    = 1'b0;
        dsp_we   = 1'b0;
        drain(8);
        check("clrZ_count", {18'd0, buf_count}, 0);
        check("clrZ_ovf", {31'd0, overflow}, 0);
        rd(0, 8'h00);

        put_char(7'h0D);
        tick();
        tick();
        check("midlf_count", {18'd0, buf_count}, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstlf_count", {18'd0, buf_count}, 0);
        drain(6);
        check("rstlf_after", {18'd0, buf_count}, 0);
        check("rstlf_din", {24'd0, ioctl_din}, 0);

        for (int i = 0; i < 8191; i++) begin
            put_char(7'(65 + (i % 26)));
            tick();
        end
        drain(10);
        check("fill_count", {18'd0, buf_count}, 8191);
        check("fill_ovf0", {31'd0, overflow}, 0);
        put_char(7'h0D);
        drain(8);
        check("fullcr_count", {18'd0, buf_count}, 8192);
        check("fullcr_ovf", {31'd0, overflow}, 1);
        rd(8191, 8'h0D); rd(8190, 8'h41); rd(8189, 8'h5A); rd(100, 8'h57);
        put_char(7'h41);
        drain(8);
        check("full_extra", {18'd0, buf_count}, 8192);

        drain(3);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
